// File: rtl/serdes_tx_link_ctrl_pkg.sv
// Shared types and constants for the SerDes TX link-layer sequencer:
// word/lane-group widths, link state encoding and default link words.
package serdes_tx_pkg;

  localparam int GRP0_W = 24;
  localparam int GRP1_W = 16;
  localparam int WORD_W = GRP0_W + GRP1_W;
  localparam int N_GRP  = 2;

  typedef enum logic [1:0] {
    LS_OFF    = 2'd0,
    LS_TRAIN  = 2'd1,
    LS_ACTIVE = 2'd2
  } link_state_e;

  localparam logic [WORD_W-1:0] TRAIN_PATTERN_DEF = 40'hAA_AAAA_AAAA;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF     = 40'h00_0000_00BC;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF     = 40'h00_0000_007C;

  // Training alternates the pattern with its inverse to exercise every lane bit.
  function automatic logic [WORD_W-1:0] train_word(input logic [WORD_W-1:0] pat,
                                                   input logic odd);
    return odd ? ~pat : pat;
  endfunction

endpackage

// File: rtl/serdes_tx_link_ctrl_if.sv
// Payload stream (valid/ready) between the TX packetizer and the link controller.
interface serdes_tx_link_ctrl_if;
  import serdes_tx_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/serdes_tx_link_ctrl_timer.sv
// serdes_tx_timer: up-counter over 0..MAX-1 with synchronous clear, an
// increment enable and a terminal-count flag; wraps to 0 after terminal count.
module serdes_tx_timer #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serdes_tx_link_ctrl.sv
// Link-layer sequencer for the 5-lane LVDS TX serializer: OFF -> TRAIN -> ACTIVE,
// payload/idle word muxing and per-group tristate command.
// Optional periodic sync-word insertion: define SERDES_TX_SYNC_INSERT_EN.
module serdes_tx_link_ctrl
  import serdes_tx_pkg::*;
#(
  parameter int                TRAIN_CYCLES  = 64,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD     = IDLE_WORD_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int                SYNC_INTERVAL = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  retrain,
  input  logic [N_GRP-1:0]      grp_en,
  serdes_tx_link_ctrl_if.slave  s,
  output logic [WORD_W-1:0]     ser_din,
  output logic [N_GRP-1:0]      serd_cmd,
  output logic [1:0]            link_state,
  output logic                  train_done
);

  link_state_e       state_q, state_d;
  logic [WORD_W-1:0] ser_din_q, ser_din_d;
  logic [N_GRP-1:0]  serd_cmd_q, serd_cmd_d;
  logic              train_done_q, train_done_d;
  logic              train_odd_q, train_odd_d;
  logic              train_tc;
  logic              sync_slot;
  logic              s_ready;
  logic              accept;

  serdes_tx_timer #(.MAX(TRAIN_CYCLES)) u_train_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != LS_TRAIN),
    .inc     (state_q == LS_TRAIN),
    .tc      (train_tc)
  );

`ifdef SERDES_TX_SYNC_INSERT_EN
  logic sync_tc;

  // Counts ACTIVE cycles from 0 on entry; the terminal count is the sync slot.
  serdes_tx_timer #(.MAX(SYNC_INTERVAL)) u_sync_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != LS_ACTIVE),
    .inc     (state_q == LS_ACTIVE),
    .tc      (sync_tc)
  );

  assign sync_slot = (state_q == LS_ACTIVE) && sync_tc;
`else
  assign sync_slot = 1'b0;
`endif

  assign s_ready   = (state_q == LS_ACTIVE) && enable && !retrain && !sync_slot;
  assign s.s_ready = s_ready;
  assign accept    = s.s_valid && s_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    ser_din_d    = ser_din_q;
    train_done_d = train_done_q;
    train_odd_d  = 1'b0;

    if (!enable) begin
      state_d      = LS_OFF;
      ser_din_d    = '0;
      train_done_d = 1'b0;
    end else begin
      case (state_q)
        LS_OFF:   state_d = LS_TRAIN;
        LS_TRAIN: begin
          ser_din_d   = train_word(TRAIN_PATTERN, train_odd_q);
          train_odd_d = !train_odd_q;
          if (train_tc) begin
            state_d      = LS_ACTIVE;
            train_done_d = 1'b1;
          end
        end
        LS_ACTIVE: begin
          if (retrain) begin
            state_d      = LS_TRAIN;
            train_done_d = 1'b0;
            ser_din_d    = IDLE_WORD;
          end else if (sync_slot) begin
            ser_din_d = SYNC_WORD;
          end else if (accept) begin
            ser_din_d = s.s_data;
          end else begin
            ser_din_d = IDLE_WORD;
          end
        end
        default:  state_d = LS_OFF;
      endcase
    end

    // Lanes follow the state being entered, so enable=0 tristates on the same edge.
    serd_cmd_d = (state_d == LS_OFF) ? {N_GRP{1'b1}} : ~grp_en;
  end

  // NOTE: synchronous reset sampled at clk; non-blocking so all state updates together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= LS_OFF;
      ser_din_q    <= '0;
      serd_cmd_q   <= {N_GRP{1'b1}};
      train_done_q <= 1'b0;
      train_odd_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ser_din_q    <= ser_din_d;
      serd_cmd_q   <= serd_cmd_d;
      train_done_q <= train_done_d;
      train_odd_q  <= train_odd_d;
    end
  end

  assign ser_din    = ser_din_q;
  assign serd_cmd   = serd_cmd_q;
  assign link_state = state_q;
  assign train_done = train_done_q;

endmodule

// File: tb/tb_serdes_tx_link_ctrl.sv
// Scoreboard bench for serdes_tx_link_ctrl (TRAIN_CYCLES=4, SYNC_INTERVAL=4):
// stimulus queues the expected response per cycle, a monitor pops and compares.
module tb_serdes_tx_link_ctrl;
  import serdes_tx_pkg::*;

  localparam logic [39:0] P = 40'hAA_AAAA_AAAA;
  localparam logic [39:0] N = 40'h55_5555_5555;
  localparam logic [39:0] I = 40'h00_0000_00BC;
  localparam logic [39:0] Z = 40'h0;
`ifdef SERDES_TX_SYNC_INSERT_EN
  localparam logic [39:0] S = 40'h00_0000_007C;
`endif

  typedef struct {
    logic        chk_rdy;
    logic        rdy;
    logic [39:0] din;
    logic [1:0]  cmd;
    logic [1:0]  st;
    logic        td;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        retrain = 1'b0;
  logic [1:0]  grp_en = 2'b11;
  logic [39:0] ser_din;
  logic [1:0]  serd_cmd;
  logic [1:0]  link_state;
  logic        train_done;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  serdes_tx_link_ctrl_if s_if ();

  serdes_tx_link_ctrl #(
    .TRAIN_CYCLES  (4),
    .SYNC_INTERVAL (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .retrain    (retrain),
    .grp_en     (grp_en),
    .s          (s_if),
    .ser_din    (ser_din),
    .serd_cmd   (serd_cmd),
    .link_state (link_state),
    .train_done (train_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus plus the response expected for it.
  task automatic step(input int rn, input int en, input int rt, input int ge,
                      input int v, input logic [39:0] d,
                      input int crdy, input int rdy, input logic [39:0] din,
                      input int cmd, input int st, input int td);
    exp_t e;
    @(negedge clk);
    reset_n       = rn[0];
    enable        = en[0];
    retrain       = rt[0];
    grp_en        = ge[1:0];
    s_if.s_valid  = v[0];
    s_if.s_data   = d;
    e.chk_rdy = crdy[0];
    e.rdy     = rdy[0];
    e.din     = din;
    e.cmd     = cmd[1:0];
    e.st      = st[1:0];
    e.td      = td[0];
    exp_q.push_back(e);
  endtask

  // Monitor: s_ready checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        if (cur.chk_rdy) check("s_ready", {39'd0, s_if.s_ready}, {39'd0, cur.rdy});
        @(posedge clk);
        #1;
        check("ser_din", ser_din, cur.din);
        check("serd_cmd", {38'd0, serd_cmd}, {38'd0, cur.cmd});
        check("link_state", {38'd0, link_state}, {38'd0, cur.st});
        check("train_done", {39'd0, train_done}, {39'd0, cur.td});
        exp_q.delete(0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // reset held with enable=1, then training
    step(0,1,0,3,0,Z,      1,0, Z,3,0,0);
    step(0,1,0,3,0,Z,      1,0, Z,3,0,0);
    step(1,1,0,3,0,Z,      1,0, Z,0,1,0);
    step(1,1,0,3,0,Z,      1,0, P,0,1,0);
    step(1,1,0,3,0,Z,      1,0, N,0,1,0);
    step(1,1,0,3,0,Z,      1,0, P,0,1,0);
    step(1,1,0,3,0,Z,      1,0, N,0,2,1);
    step(1,1,0,3,0,Z,      1,1, I,0,2,1);

`ifdef SERDES_TX_SYNC_INSERT_EN
    // continuous payload; 4th ACTIVE cycle is a sync slot
    step(1,1,0,3,1,40'd1,  1,1, 40'd1,0,2,1);
    step(1,1,0,3,1,40'd2,  1,1, 40'd2,0,2,1);
    step(1,1,0,3,1,40'd3,  1,0, S,0,2,1);
    step(1,1,0,3,1,40'd3,  1,1, 40'd3,0,2,1);
    step(1,1,0,3,1,40'd4,  1,1, 40'd4,0,2,1);
    step(1,1,0,3,1,40'd5,  1,1, 40'd5,0,2,1);
    step(1,1,0,3,1,40'd6,  1,0, S,0,2,1);
    step(1,1,0,3,1,40'd6,  1,1, 40'd6,0,2,1);
    step(1,0,0,3,0,Z,      1,0, Z,3,0,0);
`else
    // payload 1,2,3, gap, 4
    step(1,1,0,3,1,40'd1,  1,1, 40'd1,0,2,1);
    step(1,1,0,3,1,40'd2,  1,1, 40'd2,0,2,1);
    step(1,1,0,3,1,40'd3,  1,1, 40'd3,0,2,1);
    step(1,1,0,3,0,Z,      1,1, I,0,2,1);
    step(1,1,0,3,1,40'd4,  1,1, 40'd4,0,2,1);
    // group 1 disabled
    step(1,1,0,1,0,Z,      1,1, I,2,2,1);
    // retrain with a pending word; it is held off until ACTIVE again
    step(1,1,1,1,1,40'd5,  1,0, I,2,1,0);
    step(1,1,0,1,1,40'd5,  1,0, P,2,1,0);
    step(1,1,0,1,1,40'd5,  1,0, N,2,1,0);
    step(1,1,0,1,1,40'd5,  1,0, P,2,1,0);
    step(1,1,0,1,1,40'd5,  1,0, N,2,2,1);
    step(1,1,0,1,1,40'd5,  1,1, 40'd5,2,2,1);
    step(1,1,0,1,0,Z,      1,1, I,2,2,1);
    // enable dropped from ACTIVE
    step(1,0,0,1,1,40'd9,  1,0, Z,3,0,0);
    step(1,0,0,3,0,Z,      1,0, Z,3,0,0);
    // reset mid-TRAIN, then full retraining from count 0
    step(1,1,0,3,0,Z,      1,0, Z,0,1,0);
    step(1,1,0,3,0,Z,      1,0, P,0,1,0);
    step(0,1,0,3,0,Z,      1,0, Z,3,0,0);
    step(1,1,0,3,0,Z,      1,0, Z,0,1,0);
    step(1,1,0,3,0,Z,      1,0, P,0,1,0);
    step(1,1,0,3,0,Z,      1,0, N,0,1,0);
    step(1,1,0,3,0,Z,      1,0, P,0,1,0);
    step(1,1,0,3,0,Z,      1,0, N,0,2,1);
    step(1,1,0,3,1,40'd6,  1,1, 40'd6,0,2,1);
    // reset mid-ACTIVE
    step(0,1,0,3,1,40'd7,  0,0, Z,3,0,0);
    step(1,1,0,3,0,Z,      1,0, Z,0,1,0);
`endif

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
